fetch_stage: RTL and testbench

- IF stage of the 5-stage pipeline: owns the program counter, drives the fetch address to the combinational instruction memory, and registers the returned word into the IF/ID pipeline register.
- Handles load-use stalls, flushes and branch/jump redirects from EX.
- Sits between hazard unit/EX redirect logic and the decode stage.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/pc_reg.sv | 39 +++
 rtl/fetch_stage.sv | 75 +++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the IF stage and its consumers.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with redirect/stall next-PC selection.
// Also flags misaligned redirect targets.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic        o_misalign
);

  logic [31:0] pc_next;

  assign o_pc4 = o_pc + 32'd4;

  // Redirect beats stall: a stalled instruction is on the wrong path anyway.
  always_comb begin
    pc_next = o_pc4;
    if (i_redirect)
      pc_next = {i_redirect_pc[31:2], 2'b00};
    else if (i_stall)
      pc_next = o_pc;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pc       <= RESET_PC;
      o_misalign <= 1'b0;
    end else begin
      o_pc       <= pc_next;
      o_misalign <= i_redirect & (|i_redirect_pc[1:0]);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus the IF/ID pipeline register.
// Out-of-range fetches turn into bubbles while the PC keeps advancing.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = pipeline_pkg::RESET_PC,
  parameter int          IMEM_BYTES = 8192,
  parameter logic [31:0] NOP_INSTR  = pipeline_pkg::NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [31:0] o_pc,
  input  logic [31:0] i_instr,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc4,
  output logic [31:0] o_if_id_instr,
  output logic        o_if_id_valid,
  output logic        o_misalign,
  output logic        o_pc_oob,
  output logic [31:0] o_fetch_count
);

  import pipeline_pkg::*;

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  logic [31:0] pc4;
  if_id_t      if_id;
  logic [31:0] fetch_count;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_pc          (o_pc),
    .o_pc4         (pc4),
    .o_misalign    (o_misalign)
  );

  assign o_pc_oob = (o_pc >= IMEM_LIMIT);

  // Bubbles keep pc/pc4 so the register still points somewhere sensible.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      if_id.pc    <= 32'd0;
      if_id.pc4   <= 32'd4;
      if_id.instr <= NOP_INSTR;
      if_id.valid <= 1'b0;
      fetch_count <= 32'd0;
    end else if (i_redirect || i_flush) begin
      if_id.instr <= NOP_INSTR;
      if_id.valid <= 1'b0;
    end else if (!i_stall) begin
      if_id.pc    <= o_pc;
      if_id.pc4   <= pc4;
      if_id.instr <= o_pc_oob ? NOP_INSTR : i_instr;
      if_id.valid <= !o_pc_oob;
      if (!o_pc_oob)
        fetch_count <= fetch_count + 32'd1;
    end
  end

  assign o_if_id_pc    = if_id.pc;
  assign o_if_id_pc4   = if_id.pc4;
  assign o_if_id_instr = if_id.instr;
  assign o_if_id_valid = if_id.valid;
  assign o_fetch_count = fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] o_pc;
  logic [31:0] i_instr;
  logic        i_stall;
  logic        i_flush;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_if_id_pc;
  logic [31:0] o_if_id_pc4;
  logic [31:0] o_if_id_instr;
  logic        o_if_id_valid;
  logic        o_misalign;
  logic        o_pc_oob;
  logic [31:0] o_fetch_count;

  int n_checks = 0;
  int n_fails  = 0;

  fetch_stage dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .o_pc          (o_pc),
    .i_instr       (i_instr),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_if_id_pc    (o_if_id_pc),
    .o_if_id_pc4   (o_if_id_pc4),
    .o_if_id_instr (o_if_id_instr),
    .o_if_id_valid (o_if_id_valid),
    .o_misalign    (o_misalign),
    .o_pc_oob      (o_pc_oob),
    .o_fetch_count (o_fetch_count)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    case (o_pc)
      32'h0:   i_instr = 32'h00A0_0093;
      32'h4:   i_instr = 32'h0010_8113;
      32'h8:   i_instr = 32'h0021_0193;
      default: i_instr = {16'hABCD, o_pc[15:0]};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid);
    chk({tag, ".ifid_pc"}, o_if_id_pc, pc);
    chk({tag, ".ifid_pc4"}, o_if_id_pc4, pc + 32'd4);
    chk({tag, ".ifid_instr"}, o_if_id_instr, instr);
    chk({tag, ".ifid_valid"}, {31'd0, o_if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    i_reset = 1'b1;
    i_stall = 1'b0;
    i_flush = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = 32'd0;
    step();
    step();
    chk("rst.pc", o_pc, 32'h0);
    chk_ifid("rst", 32'h0, NOP, 1'b0);
    chk("rst.misalign", {31'd0, o_misalign}, 32'd0);
    chk("rst.count", o_fetch_count, 32'd0);
    chk("rst.oob", {31'd0, o_pc_oob}, 32'd0);
    i_reset = 1'b0;

    // free run
    step();
    chk("run1.pc", o_pc, 32'h4);
    chk_ifid("run1", 32'h0, 32'h00A0_0093, 1'b1);
    chk("run1.count", o_fetch_count, 32'd1);
    step();
    chk("run2.pc", o_pc, 32'h8);
    chk_ifid("run2", 32'h4, 32'h0010_8113, 1'b1);

    // two-cycle stall at pc 8
    i_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall.pc", o_pc, 32'h8);
      chk_ifid("stall", 32'h4, 32'h0010_8113, 1'b1);
      chk("stall.count", o_fetch_count, 32'd2);
    end
    i_stall = 1'b0;
    step();
    chk("rel.pc", o_pc, 32'hC);
    chk_ifid("rel", 32'h8, 32'h0021_0193, 1'b1);
    chk("rel.count", o_fetch_count, 32'd3);

    // redirect wins over stall
    i_stall = 1'b1;
    i_redirect = 1'b1;
    i_redirect_pc = 32'h40;
    step();
    i_stall = 1'b0;
    i_redirect = 1'b0;
    chk("redir.pc", o_pc, 32'h40);
    chk_ifid("redir", 32'h8, NOP, 1'b0);
    chk("redir.misalign", {31'd0, o_misalign}, 32'd0);
    chk("redir.count", o_fetch_count, 32'd3);
    step();
    chk("redir1.pc", o_pc, 32'h44);
    chk_ifid("redir1", 32'h40, 32'hABCD_0040, 1'b1);
    chk("redir1.count", o_fetch_count, 32'd4);

    // misaligned redirect
    i_redirect = 1'b1;
    i_redirect_pc = 32'h42;
    step();
    i_redirect = 1'b0;
    chk("mis.pc", o_pc, 32'h40);
    chk("mis.pulse", {31'd0, o_misalign}, 32'd1);
    chk("mis.valid", {31'd0, o_if_id_valid}, 32'd0);
    step();
    chk("mis1.pulse", {31'd0, o_misalign}, 32'd0);
    chk("mis1.pc", o_pc, 32'h44);
    chk_ifid("mis1", 32'h40, 32'hABCD_0040, 1'b1);
    chk("mis1.count", o_fetch_count, 32'd5);

    // flush only, then stall+flush
    i_flush = 1'b1;
    step();
    chk("flush.pc", o_pc, 32'h48);
    chk_ifid("flush", 32'h40, NOP, 1'b0);
    i_stall = 1'b1;
    step();
    chk("sflush.pc", o_pc, 32'h48);
    chk_ifid("sflush", 32'h40, NOP, 1'b0);
    chk("sflush.count", o_fetch_count, 32'd5);
    i_stall = 1'b0;
    i_flush = 1'b0;
    step();
    chk("post.pc", o_pc, 32'h4C);
    chk_ifid("post", 32'h48, 32'hABCD_0048, 1'b1);
    chk("post.count", o_fetch_count, 32'd6);

    // walk across the end of instruction memory
    i_redirect = 1'b1;
    i_redirect_pc = 32'h1FFC;
    step();
    i_redirect = 1'b0;
    chk("edge.pc", o_pc, 32'h1FFC);
    chk("edge.oob", {31'd0, o_pc_oob}, 32'd0);
    step();
    chk("oob0.pc", o_pc, 32'h2000);
    chk("oob0.oob", {31'd0, o_pc_oob}, 32'd1);
    chk_ifid("oob0", 32'h1FFC, 32'hABCD_1FFC, 1'b1);
    chk("oob0.count", o_fetch_count, 32'd7);
    step();
    chk("oob1.pc", o_pc, 32'h2004);
    chk_ifid("oob1", 32'h2000, NOP, 1'b0);
    chk("oob1.count", o_fetch_count, 32'd7);

    // 32-bit PC wrap
    i_redirect = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    step();
    i_redirect = 1'b0;
    chk("wrap0.pc", o_pc, 32'hFFFF_FFFC);
    chk("wrap0.oob", {31'd0, o_pc_oob}, 32'd1);
    step();
    chk("wrap1.pc", o_pc, 32'h0);
    chk("wrap1.oob", {31'd0, o_pc_oob}, 32'd0);
    chk_ifid("wrap1", 32'hFFFF_FFFC, NOP, 1'b0);
    step();
    chk("wrap2.pc", o_pc, 32'h4);
    chk_ifid("wrap2", 32'h0, 32'h00A0_0093, 1'b1);
    chk("wrap2.count", o_fetch_count, 32'd8);

    // async reset between edges while a misalign pulse is live
    i_redirect = 1'b1;
    i_redirect_pc = 32'h81;
    step();
    i_redirect = 1'b0;
    chk("pre_rst.misalign", {31'd0, o_misalign}, 32'd1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("arst.pc", o_pc, 32'h0);
    chk_ifid("arst", 32'h0, NOP, 1'b0);
    chk("arst.misalign", {31'd0, o_misalign}, 32'd0);
    chk("arst.count", o_fetch_count, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    step();
    chk("after_rst.pc", o_pc, 32'h4);
    chk_ifid("after_rst", 32'h0, 32'h00A0_0093, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
